// File: rtl/md_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : md_hazard_scoreboard
//  Purpose  : Decode-stage stall logic for the 5-stage pipeline. Detects
//             load-use hazards between F/D and D/X, and tracks up to MD_SLOTS
//             outstanding fixed-latency mul/div operations so F/D can be held
//             on RAW, WAW and structural (all slots busy) hazards. Each
//             mul/div completion is reported to writeback as a one-cycle pulse.
//  Ports    : clock, reset      - rising-edge clock, synchronous active-high reset
//             fd_insn, dx_insn  - instructions in the F/D and D/X latches
//             dx_valid          - dx_insn enters X this cycle (once per insn)
//             stall             - freeze PC/F-D, insert nop into D/X
//             md_count, md_full - occupied slots / all slots occupied
//             md_retire(_rd)    - a slot completes this cycle, and its dest
//             md_overflow       - sticky: an issue arrived while full
//  Revision : 1.0 - initial release
// ============================================================================
module md_hazard_scoreboard #(
    parameter int INSN_W   = 32,
    parameter int REG_AW   = 5,
    parameter int MD_SLOTS = 2,
    parameter int MD_LAT   = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [INSN_W-1:0]                 fd_insn,
    input  logic [INSN_W-1:0]                 dx_insn,
    input  logic                              dx_valid,
    output logic                              stall,
    output logic [$clog2(MD_SLOTS+1)-1:0]     md_count,
    output logic                              md_full,
    output logic                              md_retire,
    output logic [REG_AW-1:0]                 md_retire_rd,
    output logic                              md_overflow
);

    localparam int CW    = $clog2(MD_SLOTS + 1);
    localparam int CNT_W = $clog2(MD_LAT);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;
    localparam logic [4:0] ALU_SLL  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam logic [REG_AW-1:0] R30 = REG_AW'(30);
    localparam logic [REG_AW-1:0] R31 = REG_AW'(31);

    // Slot state
    logic [MD_SLOTS-1:0]              valid_q, valid_d;
    logic [MD_SLOTS-1:0][REG_AW-1:0]  rd_q,    rd_d;
    logic [MD_SLOTS-1:0][CNT_W-1:0]   cnt_q,   cnt_d;
    logic                             ovf_q,   ovf_d;

    // Instruction fields
    logic [4:0]        fd_op, fd_alu, dx_op, dx_alu;
    logic [REG_AW-1:0] fd_rd, fd_rs, fd_rt, dx_rd;
    logic              fd_is_md, md_issue;

    assign fd_op  = fd_insn[31:27];
    assign fd_alu = fd_insn[6:2];
    assign fd_rd  = fd_insn[22 +: REG_AW];
    assign fd_rs  = fd_insn[17 +: REG_AW];
    assign fd_rt  = fd_insn[12 +: REG_AW];
    assign dx_op  = dx_insn[31:27];
    assign dx_alu = dx_insn[6:2];
    assign dx_rd  = dx_insn[22 +: REG_AW];

    assign fd_is_md = (fd_op == OP_RTYPE) && ((fd_alu == ALU_MUL) || (fd_alu == ALU_DIV));
    assign md_issue = dx_valid && (dx_op == OP_RTYPE) && ((dx_alu == ALU_MUL) || (dx_alu == ALU_DIV));

    // Registers the F/D instruction touches; entries 0..2 are sources, 3 is
    // the destination. Unused entries are r0, which never matches anything.
    logic [REG_AW-1:0] chk [4];
    logic              fd_nop;
    assign fd_nop = (fd_insn == '0);

    always_comb begin
        for (int k = 0; k < 4; k++) chk[k] = '0;
        if (!fd_nop) begin
            if ((fd_op == OP_RTYPE) || (fd_op == OP_ADDI) || (fd_op == OP_LW) ||
                (fd_op == OP_SW) || (fd_op == OP_BNE) || (fd_op == OP_BLT))
                chk[0] = fd_rs;
            if ((fd_op == OP_RTYPE) && (fd_alu != ALU_SLL) && (fd_alu != ALU_SRL))
                chk[1] = fd_rt;
            if ((fd_op == OP_SW) || (fd_op == OP_BNE) || (fd_op == OP_BLT) || (fd_op == OP_JR))
                chk[2] = fd_rd;
            else if (fd_op == OP_BEX)
                chk[2] = R30;
            if ((fd_op == OP_RTYPE) || (fd_op == OP_ADDI) || (fd_op == OP_LW))
                chk[3] = fd_rd;
            else if (fd_op == OP_JAL)
                chk[3] = R31;
            else if (fd_op == OP_SETX)
                chk[3] = R30;
        end
    end

    // Pending-set membership. A retiring slot is still valid this cycle, so
    // its destination keeps blocking until the writeback has happened.
    logic [3:0] hit;
    always_comb begin
        hit = '0;
        for (int k = 0; k < 4; k++) begin
            if (chk[k] != '0) begin
                if (md_issue && (dx_rd == chk[k])) hit[k] = 1'b1;
                for (int s = 0; s < MD_SLOTS; s++)
                    if (valid_q[s] && (rd_q[s] == chk[k])) hit[k] = 1'b1;
            end
        end
    end

    logic load_use, structural;
    assign load_use = (dx_op == OP_LW) && (dx_rd != '0) &&
                      ((dx_rd == chk[0]) || (dx_rd == chk[1]) || (dx_rd == chk[2]));
    // Same-cycle retirement is deliberately not credited here.
    assign structural = fd_is_md && ((32'(md_count) + 32'(md_issue)) >= MD_SLOTS);
    assign stall = load_use || (|hit) || structural;

    // Occupancy and retirement from registered slot state
    always_comb begin
        md_count     = '0;
        md_retire    = 1'b0;
        md_retire_rd = '0;
        for (int s = 0; s < MD_SLOTS; s++) begin
            md_count = md_count + CW'(valid_q[s]);
            // Fixed latency means at most one slot reaches zero per cycle.
            if (valid_q[s] && (cnt_q[s] == '0)) begin
                md_retire    = 1'b1;
                md_retire_rd = md_retire_rd | rd_q[s];
            end
        end
    end
    assign md_full     = (md_count == CW'(MD_SLOTS));
    assign md_overflow = ovf_q;

    // Slot next state: age/retire first, then let the issue take the lowest
    // free slot, which includes one freed by retirement at this edge.
    always_comb begin
        logic done;
        valid_d = valid_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        for (int s = 0; s < MD_SLOTS; s++) begin
            if (valid_q[s]) begin
                if (cnt_q[s] == '0) valid_d[s] = 1'b0;
                else                cnt_d[s]   = cnt_q[s] - CNT_W'(1);
            end
        end
        if (md_issue && !md_full) begin
            for (int s = 0; s < MD_SLOTS; s++) begin
                if (!valid_d[s] && !done) begin
                    valid_d[s] = 1'b1;
                    rd_d[s]    = dx_rd;
                    cnt_d[s]   = CNT_W'(MD_LAT - 1);
                    done       = 1'b1;
                end
            end
        end
        ovf_d = ovf_q || (md_issue && md_full);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Immediate/shamt bits carry no hazard information.
    logic w_unused;
    assign w_unused = ^{fd_insn[11:7], fd_insn[1:0], dx_insn[21:7], dx_insn[1:0]};

endmodule
`default_nettype wire
